// File: rtl/fetch_unit.sv
// Instruction fetch stage: latches the PC, runs a req/ack read against
// instruction memory and holds the fetched word for the decoder under a
// valid/ready handshake. A taken jump (flush) discards wrong-path work.
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_imem_req;
  logic [ADDR_W-1:0]    r_imem_addr;
  logic                 r_instr_valid;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_instr_addr;
  logic                 w_wait_ack;

  // A live read completing in WAIT is the only non-jump reason to move the PC.
  assign w_wait_ack = (r_state == S_WAIT) & imem_ack;
  assign pc_advance = flush | (w_wait_ack & ~flush);

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_addr  = r_instr_addr;

  // Fetch FSM with registered outputs; a request, once raised, is held until
  // the memory acks it, so a flush mid-read goes through DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // On a flush the PC is loading its target this edge, so wait a cycle.
          if (!flush) begin
            r_imem_addr <= pc_addr;
            r_imem_req  <= 1'b1;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_instr       <= imem_rdata;
              r_instr_addr  <= r_imem_addr;
              r_instr_valid <= 1'b1;
              r_state       <= S_FULL;
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Wrong-path read: wait out the ack and throw the data away.
          if (imem_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_FULL: begin
          // A flush voids any same-cycle handshake with the decoder.
          if (flush) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_imem_addr   <= pc_addr;
            r_imem_req    <= 1'b1;
            r_state       <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a PC-stage model, a memory model with configurable or
// random ack latency, and an in-order instruction-stream reference.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] pc_addr = '0;
  logic          flush = 1'b0;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          instr_ready = 1'b0;
  logic          pc_advance;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_addr;

  int n_checks = 0;
  int n_fail = 0;

  // Reference state: PC stage, memory, and the expected instruction stream.
  logic [AW-1:0] pc_m = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] mem_addr_m = '0;
  logic [AW-1:0] last_req_addr = '0;
  bit exp_valid = 0, mem_busy = 0, mem_live = 0, rand_lat = 0;
  int mem_lat = 0, mem_cnt = 0;
  bit s_req, s_new_req, s_ack, s_valid, s_adv, s_consumed;
  logic [AW-1:0] s_cons_addr = '0;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc_addr),
    .pc_advance (pc_advance),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_addr (instr_addr)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check, then advance the PC model.
  task automatic step(input bit fl, input logic [AW-1:0] tgt, input bit rdy);
    bit ack, adv, nv;
    @(negedge clk);
    ack = 0;
    s_new_req = 0;
    if (mem_busy) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", 32'(imem_addr), 32'(mem_addr_m));
    end else if (imem_req) begin
      mem_busy = 1;
      mem_live = 1;
      mem_addr_m = imem_addr;
      last_req_addr = imem_addr;
      s_new_req = 1;
      mem_cnt = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
    end
    if (mem_busy) ack = (mem_cnt == 0);
    flush = fl;
    instr_ready = rdy;
    imem_ack = ack;
    imem_rdata = ack ? rom(mem_addr_m) : IW'($urandom);
    #1;
    adv = fl | (ack & mem_live);
    s_req = imem_req;
    s_ack = ack;
    s_valid = instr_valid;
    s_adv = pc_advance;
    s_consumed = 0;
    check("pc_advance", 32'(pc_advance), 32'(adv));
    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    check("no_req_while_full", 32'(instr_valid & imem_req), 32'd0);
    if (exp_valid) begin
      check("instr_addr", 32'(instr_addr), 32'(exp_addr));
      check("instr", 32'(instr), 32'(rom(exp_addr)));
    end
    if (exp_valid & rdy & ~fl) begin
      s_consumed = 1;
      s_cons_addr = exp_addr;
      exp_addr = exp_addr + 1'b1;
    end
    if (fl) nv = 0;
    else if (exp_valid & rdy) nv = 0;
    else if (ack & mem_live) nv = 1;
    else nv = exp_valid;
    if (ack) mem_busy = 0;
    else if (mem_busy) begin
      mem_cnt--;
      if (fl) mem_live = 0;
    end
    exp_valid = nv;
    if (fl) exp_addr = tgt;
    @(posedge clk);
    #1;
    if (fl) pc_m = tgt;
    else if (adv) pc_m = pc_m + 1'b1;
    pc_addr = pc_m;
  endtask

  // Step (no flush) until an event: 0 new request, 1 ack, 2 consumption.
  task automatic wait_ev(input int which, input bit rdy, input string tag);
    bit found;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, '0, rdy);
      if ((which == 0 && s_new_req) || (which == 1 && s_ack) || (which == 2 && s_consumed)) begin
        found = 1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Asynchronous reset 2 time units after the call, checked before any edge.
  task automatic do_reset(input logic [AW-1:0] pc0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_addr", 32'(instr_addr), 32'd0);
    flush = 0;
    imem_ack = 0;
    instr_ready = 0;
    pc_m = pc0;
    pc_addr = pc0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_valid = 0;
    mem_busy = 0;
    mem_live = 0;
    exp_addr = pc0;
  endtask

  initial begin
    logic [5:0] vb, ab, rb;
    int lat_cnt;
    bit seen;

    // 1: zero-wait memory, decoder always ready, PC from 0.
    do_reset(8'h00);
    mem_lat = 0;
    vb = '0; ab = '0; rb = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 1);
      vb = {vb[4:0], s_valid};
      ab = {ab[4:0], s_adv};
      rb = {rb[4:0], s_req};
    end
    check("t1_valid_pattern", 32'(vb), 32'(6'b010101));
    check("t1_adv_pattern", 32'(ab), 32'(6'b101010));
    check("t1_req_pattern", 32'(rb), 32'(6'b101010));

    // 2: three ack wait cycles, decoder stalls for four cycles.
    mem_lat = 3;
    wait_ev(0, 0, "t2_req");
    lat_cnt = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, '0, 0);
      lat_cnt++;
      if (s_valid) begin
        seen = 1;
        break;
      end
    end
    check("t2_valid_seen", 32'(seen), 32'd1);
    check("t2_latency", 32'(lat_cnt), 32'd4);
    repeat (4) step(0, '0, 0);
    step(0, '0, 1);

    // 3: flush in WAIT, ack two cycles later -> DRAIN, then fetch target.
    mem_lat = 2;
    wait_ev(0, 1, "t3_req");
    step(1, 8'h40, 1);
    wait_ev(0, 1, "t3_req_after_flush");
    check("t3_target_addr", 32'(last_req_addr), 32'h40);
    wait_ev(2, 1, "t3_consume");
    check("t3_consumed_addr", 32'(s_cons_addr), 32'h40);

    // 4a: flush in the same cycle as ack.
    mem_lat = 0;
    wait_ev(2, 1, "t4_consume_pre");
    step(1, 8'h80, 1);
    wait_ev(0, 1, "t4a_req");
    check("t4a_target_addr", 32'(last_req_addr), 32'h80);
    // 4b: flush in FULL with instr_ready high.
    wait_ev(1, 1, "t4b_ack");
    step(1, 8'hC0, 1);
    wait_ev(0, 1, "t4b_req");
    check("t4b_target_addr", 32'(last_req_addr), 32'hC0);

    // 5: sequential run across the 0xFF -> 0x00 wrap.
    step(1, 8'hFF, 1);
    wait_ev(0, 1, "t5_req_ff");
    check("t5_addr_ff", 32'(last_req_addr), 32'hFF);
    wait_ev(0, 1, "t5_req_00");
    check("t5_addr_00", 32'(last_req_addr), 32'h00);

    // 6: asynchronous reset mid-WAIT, then mid-FULL; restart from new PC.
    mem_lat = 5;
    wait_ev(0, 1, "t6_req");
    step(0, '0, 1);
    do_reset(8'h20);
    step(0, '0, 1);
    check("t6_restart_req", 32'(s_new_req), 32'd1);
    check("t6_restart_addr", 32'(last_req_addr), 32'h20);
    mem_lat = 0;
    wait_ev(1, 0, "t6_ack");
    check("t6_full_before_reset", 32'(instr_valid), 32'd1);
    do_reset(8'h33);
    step(0, '0, 1);
    check("t6_restart_addr2", 32'(last_req_addr), 32'h33);

    // Random traffic: random latency, stalls and jumps.
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), AW'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage, directly downstream of the program counter.
- Takes the current PC value, runs a req/ack read against instruction memory, and holds the fetched word for the decoder under a valid/ready handshake.
- Produces the PC's advance enable.
- Discards wrong-path work when execute signals a taken jump (flush).

Parameters:
ADDR_W, 8, width of program addresses (matches the PC stage)
INSTR_W, 16, width of an instruction word

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset
pc_addr  input  ADDR_W  current PC value
pc_advance  output  1  PC update enable; the PC stage holds its value when low
flush  input  1  taken jump this cycle; the PC loads its jump target on this edge
imem_req  output  1  instruction memory read request
imem_addr  output  ADDR_W  read address, stable while imem_req is high
imem_ack  input  1  memory completes the read this cycle; imem_rdata valid this cycle
imem_rdata  input  INSTR_W  read data
instr_valid  output  1  instr/instr_addr hold a valid instruction
instr_ready  input  1  decoder accepts the instruction
instr  output  INSTR_W  fetched instruction
instr_addr  output  ADDR_W  address the instruction was fetched from

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- While rst_n is low: state=IDLE; imem_req, imem_addr, instr_valid, instr, instr_addr all 0. Takes effect immediately, mid-operation included.
- Instruction memory must tolerate an abandoned request when imem_req drops on reset.

pc_advance (combinational) = flush | (state==WAIT & imem_ack & ~flush).

FSM states and transitions:
- IDLE:
  - flush=1: stay IDLE. pc_addr changes on this edge, so no latch.
  - Otherwise: imem_addr<=pc_addr, imem_req<=1, go WAIT.
- WAIT:
  - imem_req=1; imem_addr held.
  - ack & ~flush: instr<=imem_rdata, instr_addr<=imem_addr, instr_valid<=1, imem_req<=0, go FULL. pc_advance=1, so the PC increments on this edge.
  - ack & flush: data discarded, imem_req<=0, go IDLE.
  - ~ack & flush: go DRAIN. imem_req stays 1 until ack, because the protocol forbids withdrawing a request.
  - Otherwise: stay WAIT.
- DRAIN:
  - imem_req=1; on ack: data discarded, imem_req<=0, go IDLE.
  - flush in DRAIN only raises pc_advance; state unaffected.
- FULL:
  - instr_valid=1; instr/instr_addr stable.
  - flush: instr_valid<=0, go IDLE. flush has priority over instr_ready; a same-cycle handshake is void and the decoder must not consume.
  - instr_ready & ~flush: transfer occurs. instr_valid<=0, imem_addr<=pc_addr, imem_req<=1, go WAIT.
  - Otherwise: hold.

Timing and widths:
- Zero-wait memory (ack in the first req cycle) gives throughput of one instruction per 2 cycles. Latency from entering WAIT to instr_valid is 1 cycle plus the number of ack wait cycles.
- No address arithmetic inside the block. Addresses wrap only via the PC stage (0xFF -> 0x00); fetch handles 0xFF like any other address.
- imem_rdata is sampled only in ack cycles. imem_ack outside WAIT/DRAIN is ignored.

Test Plan:
1. Reset then run, zero-wait memory, instr_ready=1, ROM[a]=0x1000+a, PC starts at 0 -> imem_req high 1 cycle after reset release. instr=0x1000/0x1001/0x1002 with instr_addr 0/1/2, one every 2 cycles. pc_advance pulses once per fetch.
2. Memory acks after 3 wait cycles; decoder holds instr_ready=0 for 4 cycles -> imem_addr stable through the wait; instr_valid=1 with instr constant until ready; no new req while FULL.
3. flush during WAIT with ack 2 cycles later -> DRAIN keeps imem_req=1 until ack; data discarded and instr_valid stays 0. Next fetch uses the jump target (e.g. 0x40) as imem_addr.
4. flush in the same cycle as ack, and flush in FULL with instr_ready=1 -> no instr_valid for the discarded words; state IDLE; next imem_addr = target.
5. PC at 0xFF, sequential run -> fetch at 0xFF then 0x00; instr_addr 0xFF then 0x00.
6. rst_n pulled low mid-WAIT and mid-FULL -> all outputs 0 asynchronously, before the next clk edge. After release, fetch restarts from the pc_addr presented in IDLE.
